// File: rtl/serial_addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor.
//   op_e    : per-word operation, latched on the first digit of a word.
//   state_e : word framing state (IDLE = next beat is a first digit).
package serial_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT_W-bit add/subtract slice.
// Ports:
//   a, b      : operand digits
//   cin       : carry into the digit LSB
//   sub       : 1 = use ~b (subtract with cin = 1 on the first digit)
//   s         : result digit
//   c_out     : carry out of the digit MSB
//   c_msb_in  : carry into the digit MSB (used for signed overflow)
module addsub_digit
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic [DIGIT_W-1:0] s,
  output logic               c_out,
  output logic               c_msb_in
);

  logic [DIGIT_W-1:0] w_b_eff;
  logic [DIGIT_W:0]   w_full;

  assign w_b_eff = sub ? ~b : b;
  assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, cin};

  assign s     = w_full[DIGIT_W-1:0];
  assign c_out = w_full[DIGIT_W];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
  // of the full sum without building a separate lower-bits adder.
  assign c_msb_in = w_full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1];

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor, LSB digit first.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   vld, last       : input beat valid / final digit of the word
//   sub             : operation (0 add, 1 a-b), sampled on a word's first beat
//   a, b            : operand digits
//   out_vld         : result digit valid (one cycle after the input beat)
//   sum             : result digit
//   out_last        : result digit closes the word
//   carry_out       : final carry (subtract: 1 = no borrow), with out_last only
//   overflow        : two's-complement overflow of the word, with out_last only
//   len_err         : word force-terminated at MAX_DIGITS, with out_last only
//   dbg_state       : current framing state
// Handshake: a beat is consumed on every rising edge where vld=1; there is no
// back-pressure. Each consumed beat yields exactly one out_vld beat one cycle
// later; cycles with vld=0 change nothing and produce out_vld=0.
module serial_addsub_digit
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT_W    = 1,
  parameter int MAX_DIGITS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               last,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow,
  output logic               len_err,
  output state_e             dbg_state
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_DIGITS - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  op_e                r_op;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_first;
  logic               w_sub;
  logic               w_cin;
  logic               w_end;
  logic [DIGIT_W-1:0] w_s;
  logic               w_c_out;
  logic               w_c_msb_in;

  // On a word's first beat the live sub input sets both the operand
  // inversion and the carry-in (the +1 of two's-complement subtraction).
  assign w_first = (r_state == IDLE);
  assign w_sub   = w_first ? sub : (r_op == OP_SUB);
  assign w_cin   = w_first ? sub : r_carry;
  assign w_end   = vld & (last | (r_cnt == LAST_CNT));

  addsub_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_addsub (
    .a        (a),
    .b        (b),
    .cin      (w_cin),
    .sub      (w_sub),
    .s        (w_s),
    .c_out    (w_c_out),
    .c_msb_in (w_c_msb_in)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (vld) begin
      w_state_nxt = w_end ? IDLE : BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_ADD;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (vld) begin
      if (w_first) begin
        r_op <= op_e'(sub);
      end
      r_carry <= w_end ? 1'b0 : w_c_out;
      r_cnt   <= w_end ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      out_vld   <= vld;
      sum       <= vld ? w_s : '0;
      out_last  <= w_end;
      carry_out <= w_end & w_c_out;
      overflow  <= w_end & (w_c_msb_in ^ w_c_out);
      len_err   <= w_end & ~last;
    end
  end

  assign dbg_state = r_state;

endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
- Parametrised digit-serial adder/subtractor: consumes DIGIT_W bits of each operand per valid beat, LSB digit first, with a vld/last framing protocol.
- Successor to the 1-bit serial adder. Adds per-word add/sub mode, a registered output stream with framing, final carry/overflow flags and a word-length guard.
- Sits between serial operand sources and serial result consumers in the datapath.

Parameters:
- DIGIT_W, 1, bits processed per beat (>=1).
- MAX_DIGITS, 32, maximum digits per word before forced termination (>=2).
- CNT_W, $clog2(MAX_DIGITS+1), width of the internal digit counter (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- vld  input  1  input beat valid.
- sub  input  1  operation select (0 add, 1 subtract a-b); sampled only on the first beat of a word.
- a  input  DIGIT_W  operand A digit.
- b  input  DIGIT_W  operand B digit.
- last  input  1  final digit of the word; meaningful only with vld.
- out_vld  output  1  result digit valid.
- sum  output  DIGIT_W  result digit.
- out_last  output  1  result digit is the word's final digit.
- carry_out  output  1  final carry; for subtract, 1 = no borrow. Valid only with out_last.
- overflow  output  1  two's-complement overflow of the whole word. Valid only with out_last.
- len_err  output  1  word was force-terminated at MAX_DIGITS. Valid only with out_last.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, carry register 0, digit count 0, state IDLE, latched mode = add.
- FSM states:
  - IDLE (expecting first digit of a word).
  - BUSY (mid-word).
- IDLE, vld=1:
  - Latch op = sub.
  - Effective carry-in = sub.
  - Effective B = sub ? ~b : b.
  - Go to BUSY unless the word ends on this beat.
- BUSY, vld=1: use the latched op; carry-in = carry register. sub is ignored mid-word.
- Per beat: {c_msb_in, c_out, s} from a DIGIT_W-bit add of a + effB + cin, where c_msb_in is the carry into the digit MSB.
  - Carry register <= c_out.
  - Digit count increments.
- Word end occurs when vld & (last | count == MAX_DIGITS-1):
  - Carry register cleared to 0.
  - Count cleared to 0.
  - State returns to IDLE.
  - Next beat's carry-in is taken from the new word's sub.
- Output timing: registered, latency exactly 1 cycle from the input beat.
  - out_vld = previous vld.
  - sum = s.
  - out_last = word end.
  - carry_out = c_out.
  - overflow = c_msb_in ^ c_out.
  - len_err = word end & ~last.
  - On beats that are not a word end, carry_out, overflow and len_err are 0.
- vld=0: no state change. Carry, count and mode are held. out_vld=0 next cycle; other output registers are don't-care but are driven 0.
- last=1 with vld=0: ignored.
- Single-digit word (vld & last on the first beat): latch mode and end the word in the same cycle; out_last=1.
- Back-to-back words: a word end followed by vld on the next cycle starts a new word with no bubble.
- Reset mid-word: the partial word is discarded; no out_last is produced for it.
- Width rule: sum is exactly DIGIT_W bits; no extra growth. Word result width = digits*DIGIT_W, with carry_out as the extension bit.

Decomposition:
- Package serial_addsub_pkg holds:
  - typedef enum op_e {OP_ADD, OP_SUB}.
  - typedef enum state_e {IDLE, BUSY}.
- Sub-module addsub_digit: combinational DIGIT_W-bit adder.
  - Inputs: a, b, cin, sub.
  - Outputs: s, c_out, c_msb_in.
  - Instantiated once; the top module contains the FSM, counter and output registers.

Test Plan:
- DIGIT_W=1, add, 4-bit 5+3: a=1,0,1,0 and b=1,1,0,0 (LSB first), last on beat 4 -> sum=0,0,0,1; out_last on the 4th output; carry_out=0; overflow=1.
- DIGIT_W=1, sub, 3-5: a=1,1,0,0 and b=1,0,1,0, sub=1 on beat 1 only -> sum=0,1,1,1 (-2); carry_out=0; overflow=0.
- DIGIT_W=4, add 0xFF+0x01 with vld=0 gaps between beats, plus a stray last while vld=0 -> sum digits 0x0, 0x0; carry_out=1; overflow=0; the stray last has no effect.
- Back-to-back words: 8-bit DIGIT_W=4 add 0x7F+0x01 immediately followed by a sub of 0x10-0x01 -> first word sum 0x0,0x8 with overflow=1; second word sum 0xF,0x0 with carry_out=1 (no borrow) and overflow=0; no idle cycle between words.
- MAX_DIGITS=4, DIGIT_W=1, 6 beats with no last -> out_last and len_err=1 on the 4th output; beat 5 starts a new word with carry-in 0.
- rst_n asserted low mid-word after 2 digits, then a fresh 1+1 2-bit add -> outputs 0 during reset; new result sum=0,1 (bit0=0, bit1=1, i.e. 2); no carry leaked from the aborted word.
